// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
// Holds the FSM state encoding, requester IDs and latency-counter helpers.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Requester identifiers
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    // Latency counter width (covers MEM_LAT 1..7)
    localparam int LAT_CW = 3;

    // Counter value at which the memory data is captured.
    function automatic logic [LAT_CW-1:0] lat_last(input int lat);
        return LAT_CW'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for the memory port arbiter.
// Ports: i if_req, dm_req, mask[1:0] (bit0=if, bit1=dm), last_grant;
//        o grant_valid, grant_id.
// Macro MEM_ARB_RR_EN: ties go to the requester that is not last_grant;
// without it, ties go to the data requester.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    logic w_if_ok;
    logic w_dm_ok;
    logic w_tie_id;

    assign w_if_ok = if_req & ~mask[0];
    assign w_dm_ok = dm_req & ~mask[1];

`ifdef MEM_ARB_RR_EN
    // Alternate on a tie: favour whoever did not win last time.
    assign w_tie_id = (last_grant == REQ_IF) ? REQ_DM : REQ_IF;
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
    assign w_tie_id = REQ_DM;
`endif

    assign grant_valid = w_if_ok | w_dm_ok;

    always_comb begin
        grant_id = REQ_IF;
        if (w_if_ok && w_dm_ok) begin
            grant_id = w_tie_id;
        end else if (w_dm_ok) begin
            grant_id = REQ_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (read)
// and data (read/write) requesters; sequences arbitrate/access/respond.
// Ports: clk, rst (async, active-high);
//        if_req/if_addr -> if_ack/if_rdata;
//        dm_req/dm_wr/dm_addr/dm_wdata -> dm_ack/dm_rdata;
//        mem_enable/mem_wr/mem_addr/mem_data_in -> memory, mem_data_out <- memory;
//        busy (ACCESS state), err (sticky protocol violation).
// Macro MEM_ARB_RR_EN: round-robin tie breaking (default: data wins ties).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_enable,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy,
    output logic          err
);

    localparam logic [LAT_CW-1:0] LAT_LAST = lat_last(MEM_LAT);

    arb_state_t        r_state;
    logic [LAT_CW-1:0] r_cnt;
    logic              r_owner;
    logic              r_wr;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     r_if_rdata;
    logic [DW-1:0]     r_dm_rdata;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic              r_mem_enable;
    logic              r_mem_wr;
    logic              r_busy;
    logic              r_err;

    logic              w_last_grant;
    logic [1:0]        w_mask;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_owner_req;

    // In RESP the requester just served still holds req; hide it.
    always_comb begin
        w_mask = 2'b00;
        if (r_state == ARB_RESP) begin
            w_mask = (r_owner == REQ_DM) ? 2'b10 : 2'b01;
        end
    end

    assign w_owner_req = (r_owner == REQ_DM) ? dm_req : if_req;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .mask        (w_mask),
        .last_grant  (w_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_IF;
        end else if ((r_state != ARB_ACCESS) && w_grant_valid) begin
            r_last_grant <= w_grant_id;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = REQ_IF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_cnt        <= '0;
            r_owner      <= REQ_IF;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_wr     <= 1'b0;
            unique case (r_state)
                ARB_IDLE, ARB_RESP: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant_id;
                        r_cnt        <= '0;
                        r_state      <= ARB_ACCESS;
                        r_busy       <= 1'b1;
                        r_mem_enable <= 1'b1;
                        if (w_grant_id == REQ_DM) begin
                            r_wr     <= dm_wr;
                            r_addr   <= dm_addr;
                            r_wdata  <= dm_wdata;
                            r_mem_wr <= dm_wr;
                        end else begin
                            r_wr     <= 1'b0;
                            r_addr   <= if_addr;
                        end
                    end else begin
                        r_state <= ARB_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ARB_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_owner_req) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == LAT_LAST) begin
                        r_state <= ARB_RESP;
                        r_busy  <= 1'b0;
                        if (r_owner == REQ_DM) begin
                            r_dm_ack <= 1'b1;
                            if (!r_wr) begin
                                r_dm_rdata <= mem_data_out;
                            end
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= mem_data_out;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign dm_ack      = r_dm_ack;
    assign dm_rdata    = r_dm_rdata;
    assign mem_enable  = r_mem_enable;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_addr;
    assign mem_data_in = r_wdata;
    assign busy        = r_busy;
    assign err         = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter,
// one instance at MEM_LAT=1 and one at MEM_LAT=3.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- MEM_LAT=1 instance ----
    logic        a_if_req = 0, a_dm_req = 0, a_dm_wr = 0;
    logic [15:0] a_if_addr = 0, a_dm_addr = 0, a_dm_wdata = 0;
    logic        a_if_ack, a_dm_ack, a_men, a_mwr, a_busy, a_err;
    logic [15:0] a_if_rdata, a_dm_rdata, a_maddr, a_mdin, a_mdout;

    logic [15:0] mem [0:255];
    assign a_mdout = mem[a_maddr[7:0]];

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr),
        .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_wr(a_dm_wr),
        .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
        .mem_enable(a_men), .mem_wr(a_mwr),
        .mem_addr(a_maddr), .mem_data_in(a_mdin),
        .mem_data_out(a_mdout),
        .busy(a_busy), .err(a_err)
    );

    // ---- MEM_LAT=3 instance ----
    logic        b_if_req = 0, b_dm_req = 0, b_dm_wr = 0;
    logic [15:0] b_if_addr = 0, b_dm_addr = 0, b_dm_wdata = 0;
    logic [15:0] b_mdout = 0;
    logic        b_if_ack, b_dm_ack, b_men, b_mwr, b_busy, b_err;
    logic [15:0] b_if_rdata, b_dm_rdata, b_maddr, b_mdin;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr),
        .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_wr(b_dm_wr),
        .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_enable(b_men), .mem_wr(b_mwr),
        .mem_addr(b_maddr), .mem_data_in(b_mdin),
        .mem_data_out(b_mdout),
        .busy(b_busy), .err(b_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tie order: data first by default, fetch first under round-robin
    // (last grant before the tie is the data write).
`ifdef MEM_ARB_RR_EN
    localparam logic [15:0] FIRST_ADDR  = 16'h0020;
    localparam logic [15:0] SECOND_ADDR = 16'h0030;
`else
    localparam logic [15:0] FIRST_ADDR  = 16'h0030;
    localparam logic [15:0] SECOND_ADDR = 16'h0020;
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'h1111;
        mem[8'h30] = 16'h2222;

        // Reset state
        tick();
        chk("rst_if_ack",   {15'd0, a_if_ack}, 16'd0);
        chk("rst_dm_ack",   {15'd0, a_dm_ack}, 16'd0);
        chk("rst_men",      {15'd0, a_men},    16'd0);
        chk("rst_busy",     {15'd0, a_busy},   16'd0);
        chk("rst_err",      {15'd0, a_err},    16'd0);
        chk("rst_maddr",    a_maddr,           16'h0000);
        chk("rst_if_rdata", a_if_rdata,        16'h0000);
        rst = 1'b0;
        tick();

        // 1. fetch read, MEM_LAT=1
        a_if_req = 1; a_if_addr = 16'h0010;
        tick();
        chk("t1_men",   {15'd0, a_men},    16'd1);
        chk("t1_mwr",   {15'd0, a_mwr},    16'd0);
        chk("t1_busy",  {15'd0, a_busy},   16'd1);
        chk("t1_maddr", a_maddr,           16'h0010);
        chk("t1_noack", {15'd0, a_if_ack}, 16'd0);
        tick();
        chk("t1_ack",    {15'd0, a_if_ack}, 16'd1);
        chk("t1_rdata",  a_if_rdata,        16'hBEEF);
        chk("t1_dm_ack", {15'd0, a_dm_ack}, 16'd0);
        chk("t1_men_lo", {15'd0, a_men},    16'd0);
        a_if_req = 0;
        tick();
        chk("t1_ack_lo", {15'd0, a_if_ack}, 16'd0);
        chk("t1_hold",   a_if_rdata,        16'hBEEF);

        // 2. data write
        a_dm_req = 1; a_dm_wr = 1;
        a_dm_addr = 16'h0100; a_dm_wdata = 16'h1234;
        tick();
        chk("t2_mwr",   {15'd0, a_mwr}, 16'd1);
        chk("t2_men",   {15'd0, a_men}, 16'd1);
        chk("t2_maddr", a_maddr,        16'h0100);
        chk("t2_mdin",  a_mdin,         16'h1234);
        tick();
        chk("t2_mwr_lo", {15'd0, a_mwr},    16'd0);
        chk("t2_ack",    {15'd0, a_dm_ack}, 16'd1);
        chk("t2_rhold",  a_dm_rdata,        16'h0000);
        a_dm_req = 0; a_dm_wr = 0;
        tick();
        chk("t2_ack_lo", {15'd0, a_dm_ack}, 16'd0);

        // 3. simultaneous requests, back-to-back service
        a_if_addr = 16'h0020; a_dm_addr = 16'h0030;
        a_if_req = 1; a_dm_req = 1;
        tick();
        chk("t3_addr1", a_maddr,        16'(FIRST_ADDR));
        chk("t3_men1",  {15'd0, a_men}, 16'd1);
        tick();
`ifdef MEM_ARB_RR_EN
        chk("t3_ack1",   {15'd0, a_if_ack}, 16'd1);
        chk("t3_other1", {15'd0, a_dm_ack}, 16'd0);
        chk("t3_data1",  a_if_rdata,        16'h1111);
        a_if_req = 0;
`else
        chk("t3_ack1",   {15'd0, a_dm_ack}, 16'd1);
        chk("t3_other1", {15'd0, a_if_ack}, 16'd0);
        chk("t3_data1",  a_dm_rdata,        16'h2222);
        a_dm_req = 0;
`endif
        tick();
        chk("t3_men2",  {15'd0, a_men},  16'd1);
        chk("t3_busy2", {15'd0, a_busy}, 16'd1);
        chk("t3_addr2", a_maddr,         16'(SECOND_ADDR));
        tick();
`ifdef MEM_ARB_RR_EN
        chk("t3_ack2",  {15'd0, a_dm_ack}, 16'd1);
        chk("t3_data2", a_dm_rdata,        16'h2222);
        a_dm_req = 0;
`else
        chk("t3_ack2",  {15'd0, a_if_ack}, 16'd1);
        chk("t3_data2", a_if_rdata,        16'h1111);
        a_if_req = 0;
`endif
        tick();
        chk("t3_idle",  {15'd0, a_busy}, 16'd0);
        chk("t3_noerr", {15'd0, a_err},  16'd0);

        // 4. MEM_LAT=3 read on the second instance
        b_if_req = 1; b_if_addr = 16'h0040; b_mdout = 16'h0BAD;
        tick();
        chk("t4_men1",  {15'd0, b_men},    16'd1);
        chk("t4_busy1", {15'd0, b_busy},   16'd1);
        tick();
        chk("t4_men2",  {15'd0, b_men},    16'd0);
        chk("t4_busy2", {15'd0, b_busy},   16'd1);
        chk("t4_noack", {15'd0, b_if_ack}, 16'd0);
        tick();
        chk("t4_busy3", {15'd0, b_busy},   16'd1);
        chk("t4_noack3",{15'd0, b_if_ack}, 16'd0);
        b_mdout = 16'hCAFE;
        tick();
        chk("t4_ack",   {15'd0, b_if_ack}, 16'd1);
        chk("t4_rdata", b_if_rdata,        16'hCAFE);
        chk("t4_busy4", {15'd0, b_busy},   16'd0);
        b_if_req = 0;
        tick();
        chk("t4_ack_lo", {15'd0, b_if_ack}, 16'd0);

        // 5. owner drops req during ACCESS
        a_if_req = 1; a_if_addr = 16'h0010;
        tick();
        a_if_req = 0;
        tick();
        chk("t5_err",  {15'd0, a_err},    16'd1);
        chk("t5_ack",  {15'd0, a_if_ack}, 16'd1);
        tick();
        chk("t5_sticky", {15'd0, a_err},    16'd1);
        chk("t5_ack_lo", {15'd0, a_if_ack}, 16'd0);
        tick();
        chk("t5_sticky2", {15'd0, a_err}, 16'd1);

        // 6. reset during ACCESS
        a_dm_req = 1; a_dm_wr = 0; a_dm_addr = 16'h0030;
        tick();
        chk("t6_busy", {15'd0, a_busy}, 16'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_busy0", {15'd0, a_busy}, 16'd0);
        chk("t6_men0",  {15'd0, a_men},  16'd0);
        chk("t6_err0",  {15'd0, a_err},  16'd0);
        chk("t6_addr0", a_maddr,         16'h0000);
        a_dm_req = 0;
        tick();
        chk("t6_noack", {15'd0, a_dm_ack}, 16'd0);
        rst = 1'b0;
        tick();
        a_dm_req = 1;
        tick();
        chk("t6_men",  {15'd0, a_men},    16'd1);
        tick();
        chk("t6_ack",   {15'd0, a_dm_ack}, 16'd1);
        chk("t6_rdata", a_dm_rdata,        16'h2222);
        a_dm_req = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
